istisna_denetleyici: RTL and testbench
======================================

Name: istisna_denetleyici

Overview:
- Trap/return sequencer for the machine-mode CSR file (mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342).
- On a synchronous exception it writes mepc, mcause and mstatus through the CSR file's single write port, one write per cycle, then redirects fetch to mtvec.
- On mret it restores mstatus and redirects fetch to mepc.
- Sits beside the execute stage; stalls the pipeline while sequencing.

Parameters:
- none

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- istisna_gecerli_i  in  1  exception request, sampled in IDLE
- istisna_kodu_i  in  4  cause code: 0 misaligned jump, 2 illegal, 3 ebreak, 4 misaligned load, 6 misaligned store, 11 ecall
- istisna_ps_i  in  31  [31:1] PC of the faulting instruction
- istisna_deger_i  in  32  faulting address/instruction (used only with MTVAL_EN)
- mret_gecerli_i  in  1  mret request, sampled in IDLE
- csr_oku_veri_i  in  32  combinational read data of CSR at csr_adr_o
- csr_adr_o  out  12  CSR address for read and write
- csr_yaz_o  out  1  CSR write enable, committed at the next clock edge
- csr_veri_o  out  32  CSR write data
- durdur_o  out  1  pipeline stall
- ps_yonlendir_gecerli_o  out  1  one-cycle fetch redirect pulse
- ps_yonlendir_o  out  31  [31:1] redirect target
- mesgul_o  out  1  state != IDLE

Behaviour:
- Clock/reset: single clock clk_i; reset is synchronous, active-high on rst_i.
- Reset state and outputs: state=IDLE, latched registers=0. All outputs are 0 in IDLE with no request.
- States: IDLE, T_MEPC, T_MCAUSE, [T_MTVAL], T_MSTATUS, T_YONLENDIR, R_MSTATUS, R_YONLENDIR.
- IDLE:
  - istisna_gecerli_i=1: latch kod, ps and deger; next state T_MEPC.
  - Else if mret_gecerli_i=1: next state R_MSTATUS.
  - Exception has priority when both are high; the mret is dropped, and the pipeline flushes it.
- T_MEPC: adr=0x341, yaz=1, veri={ps_latched,1'b0}.
- T_MCAUSE: adr=0x342, yaz=1, veri={28'b0,kod}. Bit 31 is always 0 (no interrupts).
- T_MSTATUS (read-modify-write in one cycle): adr=0x300, yaz=1.
  - veri = csr_oku_veri_i with bit7 (MPIE) <= bit3 (MIE), bit3 <= 0, bits[12:11] (MPP) <= 2'b11; other bits pass through.
- T_YONLENDIR: adr=0x305, yaz=0, ps_yonlendir_gecerli_o=1, ps_yonlendir_o={csr_oku_veri_i[31:2],1'b0}.
  - Direct mode only; mtvec[1:0] ignored. Next state IDLE.
- R_MSTATUS: adr=0x300, yaz=1; veri: bit3 <= bit7, bit7 <= 1, MPP stays 2'b11.
- R_YONLENDIR: adr=0x341, yaz=0, ps_yonlendir_gecerli_o=1, ps_yonlendir_o={csr_oku_veri_i[31:2],1'b0}. Next state IDLE.
- durdur_o: 1 when state != IDLE, or when in IDLE with either request high (combinational, same cycle as acceptance).
- Timing, with acceptance edge at cycle T:
  - Exception: writes in T+1..T+3, redirect pulse at T+4.
  - mret: mstatus write at T+1, redirect pulse at T+2.
- Requests arriving while busy are ignored, not queued.
- csr_yaz_o is never high in IDLE or in the redirect states.
- Back-to-back: a new request may be accepted in the cycle immediately after the redirect pulse.
- Reset mid-sequence: returns to IDLE next edge, no further writes. Partial CSR updates already committed remain.

Optional Feature:
- MTVAL_EN defined:
  - Adds state T_MTVAL between T_MCAUSE and T_MSTATUS: adr=0x343, yaz=1, veri=latched istisna_deger_i.
  - Exception redirect moves to T+5.
- MTVAL_EN undefined: istisna_deger_i is unused and 0x343 is never addressed.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, mesgul_o=0.
- ecall: kod=11, ps=0x80000104>>1, mstatus=0x00000008, mtvec=0x80000200 ->
  - T+1 write 0x341=0x80000104
  - T+2 write 0x342=0x0000000B
  - T+3 write 0x300=0x00001880
  - T+4 redirect target 0x80000200 (ps_yonlendir_o=0x40000100)
  - durdur_o high from T through T+4.
- mret with mstatus=0x00001880, mepc=0x80000108 ->
  - T+1 write 0x300=0x00001888
  - T+2 redirect to 0x80000108.
- istisna and mret high in the same cycle -> exception sequence only; second istisna pulse at T+2 ignored.
- rst_i asserted at T+2 of an exception -> IDLE at T+3, no mstatus write, no redirect.
- MTVAL_EN, kod=4, deger=0x00001003 -> T+3 write 0x343=0x00001003, redirect at T+5.

Source files
------------

// File: rtl/istisna_denetleyici.sv
// Machine-mode trap/return sequencer: drives the CSR file's single write port and redirects fetch.
// Optional MTVAL_EN adds an mtval (0x343) write between mcause and mstatus.
module istisna_denetleyici (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        istisna_gecerli_i,
  input  logic [3:0]  istisna_kodu_i,
  input  logic [31:1] istisna_ps_i,
  input  logic [31:0] istisna_deger_i,
  input  logic        mret_gecerli_i,
  input  logic [31:0] csr_oku_veri_i,
  output logic [11:0] csr_adr_o,
  output logic        csr_yaz_o,
  output logic [31:0] csr_veri_o,
  output logic        durdur_o,
  output logic        ps_yonlendir_gecerli_o,
  output logic [31:1] ps_yonlendir_o,
  output logic        mesgul_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_MEPC,
    S_T_MCAUSE,
    S_T_MTVAL,
    S_T_MSTATUS,
    S_T_YONLENDIR,
    S_R_MSTATUS,
    S_R_YONLENDIR
  } durum_t;

  durum_t      r_durum;
  durum_t      w_sonraki;
  logic [3:0]  r_kod;
  logic [31:1] r_ps;
  logic [31:0] w_mstatus;

`ifdef MTVAL_EN
  logic [31:0] r_deger;
`else
  logic        w_unused_deger;
  assign w_unused_deger = ^istisna_deger_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum <= S_IDLE;
      r_kod   <= '0;
      r_ps    <= '0;
`ifdef MTVAL_EN
      r_deger <= '0;
`endif
    end else begin
      r_durum <= w_sonraki;
      if (r_durum == S_IDLE && istisna_gecerli_i) begin
        r_kod   <= istisna_kodu_i;
        r_ps    <= istisna_ps_i;
`ifdef MTVAL_EN
        r_deger <= istisna_deger_i;
`endif
      end
    end
  end

  always_comb begin
    w_sonraki              = r_durum;
    csr_adr_o              = '0;
    csr_yaz_o              = 1'b0;
    csr_veri_o             = '0;
    durdur_o               = 1'b1;
    ps_yonlendir_gecerli_o = 1'b0;
    ps_yonlendir_o         = '0;
    mesgul_o               = (r_durum != S_IDLE);
    w_mstatus              = csr_oku_veri_i;

    case (r_durum)
      S_IDLE: begin
        durdur_o = istisna_gecerli_i | mret_gecerli_i;
        if (istisna_gecerli_i)   w_sonraki = S_T_MEPC;
        else if (mret_gecerli_i) w_sonraki = S_R_MSTATUS;
      end
      S_T_MEPC: begin
        csr_adr_o  = 12'h341;
        csr_yaz_o  = 1'b1;
        csr_veri_o = {r_ps, 1'b0};
        w_sonraki  = S_T_MCAUSE;
      end
      S_T_MCAUSE: begin
        csr_adr_o  = 12'h342;
        csr_yaz_o  = 1'b1;
        csr_veri_o = {28'd0, r_kod};
`ifdef MTVAL_EN
        w_sonraki  = S_T_MTVAL;
`else
        w_sonraki  = S_T_MSTATUS;
`endif
      end
`ifdef MTVAL_EN
      S_T_MTVAL: begin
        csr_adr_o  = 12'h343;
        csr_yaz_o  = 1'b1;
        csr_veri_o = r_deger;
        w_sonraki  = S_T_MSTATUS;
      end
`endif
      S_T_MSTATUS: begin
        // Read-modify-write of mstatus within one cycle using the combinational read port.
        w_mstatus[7]     = csr_oku_veri_i[3];
        w_mstatus[3]     = 1'b0;
        w_mstatus[12:11] = 2'b11;
        csr_adr_o        = 12'h300;
        csr_yaz_o        = 1'b1;
        csr_veri_o       = w_mstatus;
        w_sonraki        = S_T_YONLENDIR;
      end
      S_T_YONLENDIR: begin
        csr_adr_o              = 12'h305;
        ps_yonlendir_gecerli_o = 1'b1;
        ps_yonlendir_o         = {csr_oku_veri_i[31:2], 1'b0};
        w_sonraki              = S_IDLE;
      end
      S_R_MSTATUS: begin
        w_mstatus[3]     = csr_oku_veri_i[7];
        w_mstatus[7]     = 1'b1;
        w_mstatus[12:11] = 2'b11;
        csr_adr_o        = 12'h300;
        csr_yaz_o        = 1'b1;
        csr_veri_o       = w_mstatus;
        w_sonraki        = S_R_YONLENDIR;
      end
      S_R_YONLENDIR: begin
        csr_adr_o              = 12'h341;
        ps_yonlendir_gecerli_o = 1'b1;
        ps_yonlendir_o         = {csr_oku_veri_i[31:2], 1'b0};
        w_sonraki              = S_IDLE;
      end
      default: w_sonraki = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_istisna_denetleyici.sv
// Bench for istisna_denetleyici: per-cycle expected outputs queued per scenario, CSR file modelled locally.
module tb_istisna_denetleyici;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex = 1'b0;
  logic [3:0]  kod = '0;
  logic [31:1] ps = '0;
  logic [31:0] deg = '0;
  logic        mr = 1'b0;
  logic [31:0] csr_rd;
  logic [11:0] csr_adr;
  logic        csr_yaz;
  logic [31:0] csr_veri;
  logic        durdur;
  logic        rv;
  logic [31:1] hedef;
  logic        mesgul;

  logic        pl_en = 1'b0;
  logic [11:0] pl_adr = '0;
  logic [31:0] pl_dat = '0;
  logic [31:0] csr_mem [0:4095];

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        ex, mr, rs, chk;
    logic [11:0] adr;
    logic        yaz;
    logic [31:0] veri;
    logic        rv;
    logic [31:1] hedef;
    logic        dur, mes;
  } cyc_t;

  cyc_t q[$];

  istisna_denetleyici dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .istisna_gecerli_i      (ex),
    .istisna_kodu_i         (kod),
    .istisna_ps_i           (ps),
    .istisna_deger_i        (deg),
    .mret_gecerli_i         (mr),
    .csr_oku_veri_i         (csr_rd),
    .csr_adr_o              (csr_adr),
    .csr_yaz_o              (csr_yaz),
    .csr_veri_o             (csr_veri),
    .durdur_o               (durdur),
    .ps_yonlendir_gecerli_o (rv),
    .ps_yonlendir_o         (hedef),
    .mesgul_o               (mesgul)
  );

  always #5 clk = ~clk;

  // CSR file model: combinational read, write committed on the clock edge.
  assign csr_rd = csr_mem[csr_adr];
  always @(posedge clk) begin
    if (pl_en)        csr_mem[pl_adr] <= pl_dat;
    else if (csr_yaz) csr_mem[csr_adr] <= csr_veri;
  end

  function automatic cyc_t cy(input logic e, input logic m, input logic r, input logic c,
                              input logic [11:0] a, input logic y, input logic [31:0] v,
                              input logic p, input logic [31:0] h, input logic d, input logic b);
    cyc_t x;
    x.ex = e; x.mr = m; x.rs = r; x.chk = c;
    x.adr = a; x.yaz = y; x.veri = v; x.rv = p; x.hedef = h[31:1]; x.dur = d; x.mes = b;
    return x;
  endfunction

  function automatic cyc_t idle();
    return cy(0, 0, 0, 1, 12'h000, 0, 32'h0, 0, 32'h0, 0, 0);
  endfunction

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk); pl_en = 1'b1; pl_adr = a; pl_dat = d;
    @(negedge clk); pl_en = 1'b0;
  endtask

  task automatic test_reset();
    q.push_back(cy(0, 0, 1, 0, 12'h000, 0, 32'h0, 0, 32'h0, 0, 0));
    q.push_back(cy(0, 0, 1, 0, 12'h000, 0, 32'h0, 0, 32'h0, 0, 0));
    for (int i = 0; i < 5; i++) q.push_back(idle());
    for (int k = 0; q.size() > 0; k++) begin
      cyc_t c = q.pop_front();
      @(negedge clk); ex = c.ex; mr = c.mr; rst = c.rs;
      #1;
      if (c.chk) begin
        n_chk++;
        if ({csr_adr, csr_yaz, csr_veri, rv, hedef, durdur, mesgul} !==
            {c.adr, c.yaz, c.veri, c.rv, c.hedef, c.dur, c.mes}) begin
          n_err++;
          $display("FAIL reset cyc%0d: got adr=%h yaz=%b veri=%h rv=%b hedef=%h dur=%b mes=%b, want adr=%h yaz=%b veri=%h rv=%b hedef=%h dur=%b mes=%b",
                   k, csr_adr, csr_yaz, csr_veri, rv, hedef, durdur, mesgul,
                   c.adr, c.yaz, c.veri, c.rv, c.hedef, c.dur, c.mes);
        end
      end
    end
  endtask

  task automatic test_ecall();
    logic [31:0] pc = 32'h80000104;
    preload(12'h300, 32'h00000008);
    preload(12'h305, 32'h80000200);
    kod = 4'd11; ps = pc[31:1]; deg = 32'h0;
    q.push_back(cy(1, 0, 0, 1, 12'h000, 0, 32'h0, 0, 32'h0, 1, 0));
    q.push_back(cy(0, 0, 0, 1, 12'h341, 1, 32'h80000104, 0, 32'h0, 1, 1));
    q.push_back(cy(0, 0, 0, 1, 12'h342, 1, 32'h0000000B, 0, 32'h0, 1, 1));
`ifdef MTVAL_EN
    q.push_back(cy(0, 0, 0, 1, 12'h343, 1, 32'h00000000, 0, 32'h0, 1, 1));
`endif
    q.push_back(cy(0, 0, 0, 1, 12'h300, 1, 32'h00001880, 0, 32'h0, 1, 1));
    q.push_back(cy(0, 0, 0, 1, 12'h305, 0, 32'h0, 1, 32'h80000200, 1, 1));
    q.push_back(idle());
    for (int k = 0; q.size() > 0; k++) begin
      cyc_t c = q.pop_front();
      @(negedge clk); ex = c.ex; mr = c.mr; rst = c.rs;
      #1;
      if (c.chk) begin
        n_chk++;
        if ({csr_adr, csr_yaz, csr_veri, rv, hedef, durdur, mesgul} !==
            {c.adr, c.yaz, c.veri, c.rv, c.hedef, c.dur, c.mes}) begin
          n_err++;
          $display("FAIL ecall cyc%0d: got adr=%h yaz=%b veri=%h rv=%b hedef=%h dur=%b mes=%b, want adr=%h yaz=%b veri=%h rv=%b hedef=%h dur=%b mes=%b",
                   k, csr_adr, csr_yaz, csr_veri, rv, hedef, durdur, mesgul,
                   c.adr, c.yaz, c.veri, c.rv, c.hedef, c.dur, c.mes);
        end
      end
    end
  endtask

  task automatic test_mret();
    preload(12'h300, 32'h00001880);
    preload(12'h341, 32'h80000108);
    q.push_back(cy(0, 1, 0, 1, 12'h000, 0, 32'h0, 0, 32'h0, 1, 0));
    q.push_back(cy(0, 0, 0, 1, 12'h300, 1, 32'h00001888, 0, 32'h0, 1, 1));
    q.push_back(cy(0, 0, 0, 1, 12'h341, 0, 32'h0, 1, 32'h80000108, 1, 1));
    q.push_back(idle());
    for (int k = 0; q.size() > 0; k++) begin
      cyc_t c = q.pop_front();
      @(negedge clk); ex = c.ex; mr = c.mr; rst = c.rs;
      #1;
      if (c.chk) begin
        n_chk++;
        if ({csr_adr, csr_yaz, csr_veri, rv, hedef, durdur, mesgul} !==
            {c.adr, c.yaz, c.veri, c.rv, c.hedef, c.dur, c.mes}) begin
          n_err++;
          $display("FAIL mret cyc%0d: got adr=%h yaz=%b veri=%h rv=%b hedef=%h dur=%b mes=%b, want adr=%h yaz=%b veri=%h rv=%b hedef=%h dur=%b mes=%b",
                   k, csr_adr, csr_yaz, csr_veri, rv, hedef, durdur, mesgul,
                   c.adr, c.yaz, c.veri, c.rv, c.hedef, c.dur, c.mes);
        end
      end
    end
  endtask

  // Exception and mret together: exception wins; a repeat exception while busy is ignored.
  // mtvec low bits are set to check they do not leak into the target.
  task automatic test_priority();
    logic [31:0] pc = 32'h00000010;
    preload(12'h300, 32'h00001888);
    preload(12'h305, 32'h80000203);
    kod = 4'd2; ps = pc[31:1]; deg = 32'hDEADBEEF;
    q.push_back(cy(1, 1, 0, 1, 12'h000, 0, 32'h0, 0, 32'h0, 1, 0));
    q.push_back(cy(0, 0, 0, 1, 12'h341, 1, 32'h00000010, 0, 32'h0, 1, 1));
    q.push_back(cy(1, 0, 0, 1, 12'h342, 1, 32'h00000002, 0, 32'h0, 1, 1));
`ifdef MTVAL_EN
    q.push_back(cy(0, 0, 0, 1, 12'h343, 1, 32'hDEADBEEF, 0, 32'h0, 1, 1));
`endif
    q.push_back(cy(0, 0, 0, 1, 12'h300, 1, 32'h00001880, 0, 32'h0, 1, 1));
    q.push_back(cy(0, 0, 0, 1, 12'h305, 0, 32'h0, 1, 32'h80000200, 1, 1));
    q.push_back(idle());
    q.push_back(idle());
    for (int k = 0; q.size() > 0; k++) begin
      cyc_t c = q.pop_front();
      @(negedge clk); ex = c.ex; mr = c.mr; rst = c.rs;
      #1;
      if (c.chk) begin
        n_chk++;
        if ({csr_adr, csr_yaz, csr_veri, rv, hedef, durdur, mesgul} !==
            {c.adr, c.yaz, c.veri, c.rv, c.hedef, c.dur, c.mes}) begin
          n_err++;
          $display("FAIL priority cyc%0d: got adr=%h yaz=%b veri=%h rv=%b hedef=%h dur=%b mes=%b, want adr=%h yaz=%b veri=%h rv=%b hedef=%h dur=%b mes=%b",
                   k, csr_adr, csr_yaz, csr_veri, rv, hedef, durdur, mesgul,
                   c.adr, c.yaz, c.veri, c.rv, c.hedef, c.dur, c.mes);
        end
      end
    end
  endtask

  // mret held through the redirect cycle is accepted the cycle right after it.
  task automatic test_back_to_back();
    logic [31:0] pc = 32'h00000222;
    preload(12'h300, 32'h00000000);
    kod = 4'd6; ps = pc[31:1]; deg = 32'h00000055;
    q.push_back(cy(1, 0, 0, 1, 12'h000, 0, 32'h0, 0, 32'h0, 1, 0));
    q.push_back(cy(0, 0, 0, 1, 12'h341, 1, 32'h00000222, 0, 32'h0, 1, 1));
    q.push_back(cy(0, 0, 0, 1, 12'h342, 1, 32'h00000006, 0, 32'h0, 1, 1));
`ifdef MTVAL_EN
    q.push_back(cy(0, 0, 0, 1, 12'h343, 1, 32'h00000055, 0, 32'h0, 1, 1));
`endif
    q.push_back(cy(0, 0, 0, 1, 12'h300, 1, 32'h00001800, 0, 32'h0, 1, 1));
    q.push_back(cy(0, 1, 0, 1, 12'h305, 0, 32'h0, 1, 32'h80000200, 1, 1));
    q.push_back(cy(0, 1, 0, 1, 12'h000, 0, 32'h0, 0, 32'h0, 1, 0));
    q.push_back(cy(0, 0, 0, 1, 12'h300, 1, 32'h00001880, 0, 32'h0, 1, 1));
    q.push_back(cy(0, 0, 0, 1, 12'h341, 0, 32'h0, 1, 32'h00000220, 1, 1));
    q.push_back(idle());
    for (int k = 0; q.size() > 0; k++) begin
      cyc_t c = q.pop_front();
      @(negedge clk); ex = c.ex; mr = c.mr; rst = c.rs;
      #1;
      if (c.chk) begin
        n_chk++;
        if ({csr_adr, csr_yaz, csr_veri, rv, hedef, durdur, mesgul} !==
            {c.adr, c.yaz, c.veri, c.rv, c.hedef, c.dur, c.mes}) begin
          n_err++;
          $display("FAIL back_to_back cyc%0d: got adr=%h yaz=%b veri=%h rv=%b hedef=%h dur=%b mes=%b, want adr=%h yaz=%b veri=%h rv=%b hedef=%h dur=%b mes=%b",
                   k, csr_adr, csr_yaz, csr_veri, rv, hedef, durdur, mesgul,
                   c.adr, c.yaz, c.veri, c.rv, c.hedef, c.dur, c.mes);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pc = 32'h00000100;
    preload(12'h300, 32'h00000008);
    kod = 4'd3; ps = pc[31:1]; deg = 32'h0;
    q.push_back(cy(1, 0, 0, 1, 12'h000, 0, 32'h0, 0, 32'h0, 1, 0));
    q.push_back(cy(0, 0, 0, 1, 12'h341, 1, 32'h00000100, 0, 32'h0, 1, 1));
    q.push_back(cy(0, 0, 1, 0, 12'h000, 0, 32'h0, 0, 32'h0, 0, 0));
    for (int i = 0; i < 4; i++) q.push_back(idle());
    for (int k = 0; q.size() > 0; k++) begin
      cyc_t c = q.pop_front();
      @(negedge clk); ex = c.ex; mr = c.mr; rst = c.rs;
      #1;
      if (c.chk) begin
        n_chk++;
        if ({csr_adr, csr_yaz, csr_veri, rv, hedef, durdur, mesgul} !==
            {c.adr, c.yaz, c.veri, c.rv, c.hedef, c.dur, c.mes}) begin
          n_err++;
          $display("FAIL reset_mid cyc%0d: got adr=%h yaz=%b veri=%h rv=%b hedef=%h dur=%b mes=%b, want adr=%h yaz=%b veri=%h rv=%b hedef=%h dur=%b mes=%b",
                   k, csr_adr, csr_yaz, csr_veri, rv, hedef, durdur, mesgul,
                   c.adr, c.yaz, c.veri, c.rv, c.hedef, c.dur, c.mes);
        end
      end
    end
    n_chk++;
    if (csr_mem[12'h300] !== 32'h00000008) begin
      n_err++;
      $display("FAIL reset_mid_mstatus: got %h, want %h", csr_mem[12'h300], 32'h00000008);
    end
    n_chk++;
    if (csr_mem[12'h341] !== 32'h00000100) begin
      n_err++;
      $display("FAIL reset_mid_mepc: got %h, want %h", csr_mem[12'h341], 32'h00000100);
    end
  endtask

`ifdef MTVAL_EN
  task automatic test_mtval();
    logic [31:0] pc = 32'h00002000;
    preload(12'h300, 32'h00000008);
    preload(12'h305, 32'h80000200);
    kod = 4'd4; ps = pc[31:1]; deg = 32'h00001003;
    q.push_back(cy(1, 0, 0, 1, 12'h000, 0, 32'h0, 0, 32'h0, 1, 0));
    q.push_back(cy(0, 0, 0, 1, 12'h341, 1, 32'h00002000, 0, 32'h0, 1, 1));
    q.push_back(cy(0, 0, 0, 1, 12'h342, 1, 32'h00000004, 0, 32'h0, 1, 1));
    q.push_back(cy(0, 0, 0, 1, 12'h343, 1, 32'h00001003, 0, 32'h0, 1, 1));
    q.push_back(cy(0, 0, 0, 1, 12'h300, 1, 32'h00001880, 0, 32'h0, 1, 1));
    q.push_back(cy(0, 0, 0, 1, 12'h305, 0, 32'h0, 1, 32'h80000200, 1, 1));
    q.push_back(idle());
    for (int k = 0; q.size() > 0; k++) begin
      cyc_t c = q.pop_front();
      @(negedge clk); ex = c.ex; mr = c.mr; rst = c.rs;
      #1;
      if (c.chk) begin
        n_chk++;
        if ({csr_adr, csr_yaz, csr_veri, rv, hedef, durdur, mesgul} !==
            {c.adr, c.yaz, c.veri, c.rv, c.hedef, c.dur, c.mes}) begin
          n_err++;
          $display("FAIL mtval cyc%0d: got adr=%h yaz=%b veri=%h rv=%b hedef=%h dur=%b mes=%b, want adr=%h yaz=%b veri=%h rv=%b hedef=%h dur=%b mes=%b",
                   k, csr_adr, csr_yaz, csr_veri, rv, hedef, durdur, mesgul,
                   c.adr, c.yaz, c.veri, c.rv, c.hedef, c.dur, c.mes);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ecall();
    test_mret();
    test_priority();
    test_back_to_back();
    test_reset_mid();
`ifdef MTVAL_EN
    test_mtval();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
